// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings and control-word layout for the CPU control sequencer
package cu_pkg;

    localparam int CW_W = 37;

    // State encodings; every state that is neither FETCH nor FAULT belongs to a sub-CU
    localparam logic [3:0] ST_FETCH = 4'b0000;
    localparam logic [3:0] ST_EX0   = 4'b0001;
    localparam logic [3:0] ST_EX1   = 4'b0010;
    localparam logic [3:0] ST_EX2   = 4'b0011;
    localparam logic [3:0] ST_FAULT = 4'b1111;

    typedef enum logic [1:0] {
        CLS_DP  = 2'd0,
        CLS_BR  = 2'd1,
        CLS_MEM = 2'd2
    } cls_t;

    // Field LSB offsets, packed MSB-first from bit 36; bit 0 is a spare
    localparam int F_FS          = 32;
    localparam int F_SA          = 27;
    localparam int F_SB          = 22;
    localparam int F_DA          = 17;
    localparam int F_W_REG       = 16;
    localparam int F_C0          = 15;
    localparam int F_MEM_CS      = 13;
    localparam int F_B_SEL       = 12;
    localparam int F_MEM_WE      = 11;
    localparam int F_IR_LOAD     = 10;
    localparam int F_STATUS_LOAD = 9;
    localparam int F_SIZE        = 7;
    localparam int F_ADD_TRI     = 6;
    localparam int F_DATA_TRI    = 4;
    localparam int F_PC_SEL      = 3;
    localparam int F_PC_FS       = 1;

    // Fetch word while memory is still busy: chip-select instruction port, word size, PC select
    localparam logic [CW_W-1:0] FETCH_CW = (37'd1 << F_MEM_CS) | (37'd3 << F_SIZE) | (37'd1 << F_PC_SEL);

    // Extra bits once the fetch lands: latch IR and step PC by 4
    localparam logic [CW_W-1:0] FETCH_DONE_BITS = (37'd1 << F_IR_LOAD) | (37'd1 << F_PC_FS);

    // Clears every architectural write and PC update so a stalled cycle is side-effect free
    localparam logic [CW_W-1:0] HOLD_MASK = ~((37'd1 << F_W_REG) | (37'd1 << F_MEM_WE) |
                                              (37'd1 << F_IR_LOAD) | (37'd1 << F_STATUS_LOAD) |
                                              (37'd3 << F_PC_FS));

    function automatic logic [CW_W-1:0] fetch_cw(input logic ready);
        return ready ? (FETCH_CW | FETCH_DONE_BITS) : FETCH_CW;
    endfunction

endpackage

// File: rtl/cu_class_decode.sv
// rtl/cu_class_decode.sv - instruction class decode from opcode bits IR[28:25]
module cu_class_decode
    import cu_pkg::*;
(
    input  logic [3:0] op,
    output cls_t       cls
);

    // op[3:1] = IR[28:26], op[2] = IR[27], op[0] = IR[25]; branch outranks memory
    always_comb begin
        cls = CLS_DP;
        if (op[3:1] == 3'b101) begin
            cls = CLS_BR;
        end else if (op[2] && !op[0]) begin
            cls = CLS_MEM;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - top-level control sequencer: fetch, sub-CU dispatch, stalls, fault, retire count
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int CUL     = 36,
    parameter int MAX_EX  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [31:0]  IR,
    input  logic         mem_ready,
    input  logic         freeze,
    input  logic [3:0]   ns_br,
    input  logic [3:0]   ns_dp,
    input  logic [3:0]   ns_mem,
    input  logic [CUL:0] cw_br,
    input  logic [CUL:0] cw_dp,
    input  logic [CUL:0] cw_mem,
    input  logic [2:0]   km_br,
    input  logic [2:0]   km_dp,
    input  logic [2:0]   km_mem,
    output logic [3:0]   state,
    output logic [CUL:0] controlWord,
    output logic [2:0]   k_mux,
    output logic         fault,
    output logic [31:0]  retired
);

    cls_t         cls;
    logic [3:0]   ns_sel;
    logic [CUL:0] cw_sel;
    logic [2:0]   km_sel;
    logic         in_ex;
    logic         hold_mem;
    logic [2:0]   ex_cnt;
    logic [7:0]   wait_cnt;
    logic [3:0]   state_d;
    logic [2:0]   ex_cnt_d;
    logic [7:0]   wait_cnt_d;
    logic [31:0]  retired_d;
    logic         unused_ir_bits;

    assign unused_ir_bits = ^{IR[31:29], IR[24:0]};

    cu_class_decode u_class_decode (
        .op  (IR[28:25]),
        .cls (cls)
    );

    assign in_ex    = (state != ST_FETCH) && (state != ST_FAULT);
    assign hold_mem = in_ex && (cls == CLS_MEM) && (cw_mem[F_MEM_CS +: 2] != 2'b00) && !mem_ready;
    assign fault    = (state == ST_FAULT);

    // Route the decoded class's sub-CU outputs onto one bundle
    always_comb begin
        ns_sel = ns_dp;
        cw_sel = cw_dp;
        km_sel = km_dp;
        case (cls)
            CLS_BR: begin
                ns_sel = ns_br;
                cw_sel = cw_br;
                km_sel = km_br;
            end
            CLS_MEM: begin
                ns_sel = ns_mem;
                cw_sel = cw_mem;
                km_sel = km_mem;
            end
            default: ;
        endcase
    end

    // Datapath drive: FAULT is inert, FETCH is fixed, EX passes the sub-CU word; stalls mask writes
    always_comb begin
        controlWord = '0;
        k_mux       = 3'b000;
        if (state == ST_FETCH) begin
            controlWord = fetch_cw(mem_ready);
        end else if (in_ex) begin
            controlWord = cw_sel;
            k_mux       = km_sel;
        end
        if (freeze || hold_mem) begin
            controlWord = controlWord & HOLD_MASK;
        end
    end

    // Next-state and counter update; completion is checked before the runaway limit
    always_comb begin
        state_d    = state;
        ex_cnt_d   = ex_cnt;
        wait_cnt_d = wait_cnt;
        retired_d  = retired;
        if (freeze || state == ST_FAULT) begin
            state_d = state;
        end else if (state == ST_FETCH || hold_mem) begin
            if (state == ST_FETCH) begin
                ex_cnt_d = 3'd0;
            end
            if (state == ST_FETCH && mem_ready) begin
                state_d    = ST_EX0;
                wait_cnt_d = 8'd0;
            end else if (wait_cnt >= 8'(TIMEOUT)) begin
                state_d = ST_FAULT;
            end else begin
                wait_cnt_d = wait_cnt + 8'd1;
            end
        end else if (ns_sel == ST_FETCH) begin
            state_d    = ST_FETCH;
            ex_cnt_d   = 3'd0;
            wait_cnt_d = 8'd0;
            retired_d  = retired + 32'd1;
        end else if (ex_cnt >= 3'(MAX_EX)) begin
            state_d = ST_FAULT;
        end else begin
            state_d    = ns_sel;
            ex_cnt_d   = ex_cnt + 3'd1;
            wait_cnt_d = 8'd0;
        end
    end

    // Sequencer registers with asynchronous reset back to FETCH
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_FETCH;
            ex_cnt   <= 3'd0;
            wait_cnt <= 8'd0;
            retired  <= 32'd0;
        end else begin
            state    <= state_d;
            ex_cnt   <= ex_cnt_d;
            wait_cnt <= wait_cnt_d;
            retired  <= retired_d;
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - directed self-checking bench for cu_sequencer
module tb_cu_sequencer;

    localparam logic [36:0] FCW_RDY     = 37'h00_0000_258A;
    localparam logic [36:0] FCW_WAIT    = 37'h00_0000_2188;
    localparam logic [36:0] CW_BR       = 37'h11_1111_1111;
    localparam logic [36:0] CW_BR_HELD  = 37'h11_1110_1111;
    localparam logic [36:0] CW_DP       = 37'h02_2222_2222;
    localparam logic [36:0] CW_ALL      = 37'h1F_FFFF_FFFF;
    localparam logic [36:0] CW_ALL_HELD = 37'h1F_FFFE_F1F9;
    localparam logic [36:0] CW_MEM_NOCS = 37'h00_0000_0E06;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] IR;
    logic        mem_ready;
    logic        freeze;
    logic [3:0]  ns_br, ns_dp, ns_mem;
    logic [36:0] cw_br, cw_dp, cw_mem;
    logic [2:0]  km_br, km_dp, km_mem;
    logic [3:0]  state;
    logic [36:0] controlWord;
    logic [2:0]  k_mux;
    logic        fault;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    cu_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .IR          (IR),
        .mem_ready   (mem_ready),
        .freeze      (freeze),
        .ns_br       (ns_br),
        .ns_dp       (ns_dp),
        .ns_mem      (ns_mem),
        .cw_br       (cw_br),
        .cw_dp       (cw_dp),
        .cw_mem      (cw_mem),
        .km_br       (km_br),
        .km_dp       (km_dp),
        .km_mem      (km_mem),
        .state       (state),
        .controlWord (controlWord),
        .k_mux       (k_mux),
        .fault       (fault),
        .retired     (retired)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        expect_eq("rst_state", 64'(state), 64'h0);
        expect_eq("rst_retired", 64'(retired), 64'h0);
        expect_eq("rst_fault", 64'(fault), 64'h0);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        reset_n   = 1'b0;
        IR        = 32'h1400_0004;
        mem_ready = 1'b1;
        freeze    = 1'b0;
        ns_br     = 4'd2;
        ns_dp     = 4'd1;
        ns_mem    = 4'd0;
        cw_br     = CW_BR;
        cw_dp     = CW_DP;
        cw_mem    = CW_ALL;
        km_br     = 3'd1;
        km_dp     = 3'd2;
        km_mem    = 3'd3;
        #2;
        expect_eq("init_state", 64'(state), 64'h0);
        expect_eq("init_cw", 64'(controlWord), 64'(FCW_RDY));
        expect_eq("init_kmux", 64'(k_mux), 64'h0);
        expect_eq("init_fault", 64'(fault), 64'h0);
        expect_eq("init_retired", 64'(retired), 64'h0);
        #10 reset_n = 1'b1;

        // B: FETCH -> EX0 -> EX1 -> FETCH
        step();
        expect_eq("b_ex0_state", 64'(state), 64'h1);
        expect_eq("b_ex0_kmux", 64'(k_mux), 64'h1);
        expect_eq("b_ex0_cw", 64'(controlWord), 64'(CW_BR));
        step();
        expect_eq("b_ex1_state", 64'(state), 64'h2);
        expect_eq("b_ex1_kmux", 64'(k_mux), 64'h1);
        ns_br = 4'd0;
        step();
        expect_eq("b_done_state", 64'(state), 64'h0);
        expect_eq("b_retired", 64'(retired), 64'h1);

        // Fetch waits three cycles for memory
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 expect_eq("fw_cw", 64'(controlWord), 64'(FCW_WAIT));
            step();
            expect_eq("fw_state", 64'(state), 64'h0);
        end
        mem_ready = 1'b1;
        #1 expect_eq("fw_ready_cw", 64'(controlWord), 64'(FCW_RDY));
        step();
        expect_eq("fw_ex0", 64'(state), 64'h1);
        step();
        expect_eq("fw_done", 64'(state), 64'h0);
        expect_eq("fw_retired", 64'(retired), 64'h2);

        // freeze during FETCH masks IR_load/PC_FS and holds the state
        freeze = 1'b1;
        #1 expect_eq("frz_fetch_cw", 64'(controlWord), 64'(FCW_WAIT));
        step();
        expect_eq("frz_fetch_state", 64'(state), 64'h0);
        freeze = 1'b0;

        // Data op that never completes: five EX states then FAULT
        IR    = 32'h8B00_0000;
        ns_dp = 4'd2;
        step();
        expect_eq("dp_ex0_state", 64'(state), 64'h1);
        expect_eq("dp_kmux", 64'(k_mux), 64'h2);
        expect_eq("dp_cw", 64'(controlWord), 64'(CW_DP));
        for (int i = 0; i < 4; i++) begin
            step();
            expect_eq("dp_ex_state", 64'(state), 64'h2);
        end
        step();
        expect_eq("dp_fault_state", 64'(state), 64'hF);
        expect_eq("dp_fault", 64'(fault), 64'h1);
        expect_eq("dp_fault_cw", 64'(controlWord), 64'h0);
        expect_eq("dp_fault_kmux", 64'(k_mux), 64'h0);
        expect_eq("dp_retired", 64'(retired), 64'h2);
        mem_ready = 1'b0;
        step();
        expect_eq("dp_fault_sticky", 64'(state), 64'hF);
        do_reset();

        // CBZ frozen in EX0 for four cycles
        mem_ready = 1'b1;
        IR        = 32'hB400_0000;
        ns_br     = 4'd0;
        step();
        expect_eq("cbz_ex0", 64'(state), 64'h1);
        freeze = 1'b1;
        #1 expect_eq("cbz_frz_kmux", 64'(k_mux), 64'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_eq("cbz_frz_state", 64'(state), 64'h1);
            expect_eq("cbz_frz_retired", 64'(retired), 64'h0);
            expect_eq("cbz_frz_cw", 64'(controlWord), 64'(CW_BR_HELD));
        end
        freeze = 1'b0;
        #1 expect_eq("cbz_rel_cw", 64'(controlWord), 64'(CW_BR));
        step();
        expect_eq("cbz_done", 64'(state), 64'h0);
        expect_eq("cbz_retired", 64'(retired), 64'h1);

        // Memory-class EX with mem_cs = 00 is not stalled by mem_ready low
        IR     = 32'hF840_0000;
        cw_mem = CW_MEM_NOCS;
        ns_mem = 4'd0;
        step();
        expect_eq("nocs_ex0", 64'(state), 64'h1);
        expect_eq("nocs_kmux", 64'(k_mux), 64'h3);
        mem_ready = 1'b0;
        #1 expect_eq("nocs_cw", 64'(controlWord), 64'(CW_MEM_NOCS));
        step();
        expect_eq("nocs_done", 64'(state), 64'h0);
        expect_eq("nocs_retired", 64'(retired), 64'h2);

        // LDUR waiting on memory until the timeout fault
        mem_ready = 1'b1;
        cw_mem    = CW_ALL;
        step();
        expect_eq("ldur_ex0", 64'(state), 64'h1);
        mem_ready = 1'b0;
        #1 expect_eq("ldur_hold_cw", 64'(controlWord), 64'(CW_ALL_HELD));
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            if (state !== 4'h1) bad++;
        end
        expect_eq("ldur_held_cycles", 64'(bad), 64'h0);
        step();
        expect_eq("ldur_to_state", 64'(state), 64'hF);
        expect_eq("ldur_to_fault", 64'(fault), 64'h1);
        expect_eq("ldur_to_cw", 64'(controlWord), 64'h0);
        expect_eq("ldur_to_kmux", 64'(k_mux), 64'h0);
        expect_eq("ldur_retired", 64'(retired), 64'h2);
        mem_ready = 1'b1;
        step();
        expect_eq("ldur_fault_sticky", 64'(state), 64'hF);
        expect_eq("ldur_fault_cw", 64'(controlWord), 64'h0);
        do_reset();

        // Asynchronous reset in the middle of EX1
        IR    = 32'h1400_0004;
        ns_br = 4'd2;
        step();
        expect_eq("ar_ex0", 64'(state), 64'h1);
        step();
        expect_eq("ar_ex1", 64'(state), 64'h2);
        #3 reset_n = 1'b0;
        #1;
        expect_eq("ar_state", 64'(state), 64'h0);
        expect_eq("ar_cw", 64'(controlWord), 64'(FCW_RDY));
        expect_eq("ar_kmux", 64'(k_mux), 64'h0);
        #2 reset_n = 1'b1;
        step();
        expect_eq("ar_refetch", 64'(state), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
Top-level control sequencer for the single-cycle-per-state CPU datapath.
- Owns the 4-bit state register and runs the fetch cycle itself.
- Decodes the instruction class from IR and dispatches EX states to one of three sub-control units: branch, data-processing, or memory.
- Muxes the selected unit's control word, next state and k_mux onto the datapath.
- Adds memory-wait stalling, an external freeze, a runaway/timeout fault, and a retired-instruction counter.

Parameters:
CUL, 36, MSB index of control word (word is CUL+1 = 37 bits).
MAX_EX, 4, maximum consecutive EX states per instruction before fault.
TIMEOUT, 255, maximum mem_ready wait cycles before fault.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
IR  in  32  current instruction register contents.
mem_ready  in  1  memory completed this cycle (fetch or load/store).
freeze  in  1  external stall; holds all sequencer state.
ns_br, ns_dp, ns_mem  in  4 each  next state from branch / data / memory sub-CU.
cw_br, cw_dp, cw_mem  in  CUL+1 each  control words from sub-CUs.
km_br, km_dp, km_mem  in  3 each  k_mux from sub-CUs.
state  out  4  current state (fed to all sub-CUs).
controlWord  out  CUL+1  word driving the datapath.
k_mux  out  3  constant-select to datapath.
fault  out  1  sticky fault flag.
retired  out  32  count of completed instructions.

Behaviour:
Control word field order, MSB to LSB:
- FS5, SA5, SB5, DA5, w_reg, C0, mem_cs2, B_Sel, mem_write_en, IR_load, status_load, size2, add_tri_sel, data_tri_sel2, PC_sel, PC_FS2.

States (4-bit):
- FETCH = 0000; EX0 = 0001; EX1 = 0010; EX2 = 0011; FAULT = 1111.
- EX states are owned by the sub-CUs.

Class decode (combinational, from IR):
- Branch: IR[28:26] == 101.
- Memory: IR[27] == 1 and IR[25] == 0, with branch taking priority.
- Data: everything else.

FETCH:
- controlWord = FETCH_CW: mem_cs = 01, size = 11, IR_load = mem_ready, PC_sel = 1, PC_FS = (mem_ready ? 01 : 00); all other fields 0.
- k_mux = 000.
- When mem_ready = 1, next state is EX0.
- When mem_ready = 0, remain in FETCH and increment wait_cnt.

EX states:
- controlWord, k_mux and NS are taken from the selected sub-CU.
- In a memory-class EX state with sub-CU mem_cs != 00 and mem_ready = 0: hold the state, increment wait_cnt, and force IR_load, status_load, w_reg and mem_write_en to 0 and PC_FS to 00 (HOLD_MASK).
- Sub-CU NS == 0000 ends the instruction: retired increments by 1 and next state is FETCH.

Counters:
- ex_cnt (3-bit) increments on each EX state entered and clears on FETCH.
- If ex_cnt would exceed MAX_EX, next state is FAULT.
- wait_cnt (8-bit) clears whenever mem_ready = 1 or the state changes.
- wait_cnt reaching TIMEOUT sends the sequencer to FAULT.

FAULT:
- Terminal; only reset_n exits it.
- fault = 1; controlWord = 0 (PC_FS = 00, every write enable 0); k_mux = 000.

freeze:
- state, ex_cnt, wait_cnt and retired are held.
- controlWord has HOLD_MASK applied.
- freeze has priority over mem_ready and over sub-CU NS.

Simultaneous events:
- Timeout and instruction completion in the same cycle: completion wins.
- retired wraps modulo 2^32.

Reset:
- Asynchronous assertion from any state, including mid-wait or mid-EX.
- Sets state = FETCH, ex_cnt = 0, wait_cnt = 0, retired = 0, fault = 0.
- After deassertion, outputs are FETCH_CW.

Latency:
- state is registered.
- controlWord and k_mux are combinational from state, IR and the sub-CU inputs, valid in the same cycle.

Decomposition:
- Shared package cu_pkg holds:
  - State encodings: ST_FETCH, ST_EX0, ST_EX1, ST_EX2, ST_FAULT.
  - Class encoding: CLS_BR, CLS_DP, CLS_MEM.
  - Control-word field offsets.
  - FETCH_CW and HOLD_MASK constants.
- One sub-module, cu_class_decode: combinational IR to 2-bit class.
- Counters and the FSM stay in cu_sequencer.

Test Plan:
1. Reset with mem_ready = 1 and IR = B (0x14000004); ns_br = 0010, then 0000 -> state sequence FETCH, EX0, EX1, FETCH; k_mux = km_br during EX; retired = 1.
2. Fetch with mem_ready low for 3 cycles -> state held at FETCH, IR_load = 0 and PC_FS = 00 for 3 cycles; EX0 entered on the 4th cycle.
3. LDUR (0xF8400000), sub-CU mem_cs = 01, mem_ready low for 256 cycles -> FAULT at wait 255; fault = 1; controlWord = 0 until reset_n.
4. Data op whose sub-CU never returns NS = 0000 -> FAULT after 5th EX state; retired unchanged.
5. freeze asserted in EX0 of a CBZ for 4 cycles -> state, retired and ex_cnt frozen; status_load = 0 and PC_FS = 00 throughout; normal completion after release.
6. reset_n pulsed low asynchronously mid-EX1 -> state = 0000 and controlWord = FETCH_CW immediately, without waiting for a clock edge.
